// File: rtl/ir_color_if.sv
`timescale 1ns/1ps
// Bundle between the IR decoder and its neighbours: raw receiver line in,
// colour levels and command status out.
interface ir_color_if;
  logic       ir_in;
  logic [2:0] r;
  logic [2:0] g;
  logic [2:0] b;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       frame_err;

  modport master (output ir_in, input r, g, b, cmd, cmd_valid, frame_err);
  modport slave  (input ir_in, output r, g, b, cmd, cmd_valid, frame_err);
endinterface

// File: rtl/ir_color_ctrl.sv
`timescale 1ns/1ps
// NEC infrared frame decoder that steps 3-bit r/g/b colour levels with
// saturation; repeat frames re-apply the last accepted command.
module ir_color_ctrl #(
  parameter int         TICK_DIV   = 100,
  parameter logic [7:0] ADDR       = 8'h00,
  parameter int         REPEAT_WIN = 12000
) (
  input logic       clk,
  input logic       rst_n,
  ir_color_if.slave bus
);

  localparam int          PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [10:0] W_MAX     = 11'd2047;
  localparam logic [10:0] W_TIMEOUT = 11'd1100;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, DATA_STOP, RPT_STOP
  } state_t;

  state_t        state, state_nx;
  logic          ir_p0, ir_p1, ir_p2;
  logic          edge_det, rise, fall;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [10:0]   width;
  logic [4:0]    bit_cnt;
  logic [31:0]   frame;
  logic          last_ok;
  logic [13:0]   idle_cnt;
  logic [2:0]    r_q, g_q, b_q;
  logic [7:0]    cmd_q;
  logic          valid_q, err_q;
  logic          do_shift, bit_val, clr_bits, acc_new, acc_rpt, err;
  logic          frame_ok;
  logic [7:0]    code;

  function automatic logic in_win(input logic [10:0] w, input int lo, input int hi);
    return (int'(w) >= lo) && (int'(w) <= hi);
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  // p0/p1 synchronize the asynchronous line, p2 holds the previous sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_p0 <= 1'b1;
      ir_p1 <= 1'b1;
      ir_p2 <= 1'b1;
    end else begin
      ir_p0 <= bus.ir_in;
      ir_p1 <= ir_p0;
      ir_p2 <= ir_p1;
    end
  end

  assign edge_det = ir_p1 ^ ir_p2;
  assign rise     = edge_det & ir_p1;
  assign fall     = edge_det & ~ir_p1;
  assign tick     = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      width   <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (edge_det)
        width <= '0;
      else if (tick && width != W_MAX)
        width <= width + 11'd1;
    end
  end

  assign frame_ok = (frame[7:0] == ADDR) && (frame[15:8] == ~ADDR) &&
                    (frame[31:24] == ~frame[23:16]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_shift = 1'b0;
    bit_val  = 1'b0;
    clr_bits = 1'b0;
    acc_new  = 1'b0;
    acc_rpt  = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE:       if (fall) state_nx = LEAD_MARK;
      LEAD_MARK:  if (rise) begin
                    if (in_win(width, 800, 1000)) state_nx = LEAD_SPACE;
                    else                          err = 1'b1;
                  end
      LEAD_SPACE: if (fall) begin
                    if (in_win(width, 400, 500)) begin
                      state_nx = BIT_MARK;
                      clr_bits = 1'b1;
                    end else if (in_win(width, 200, 250)) state_nx = RPT_STOP;
                    else                                  err = 1'b1;
                  end
      BIT_MARK:   if (rise) begin
                    if (in_win(width, 40, 70)) state_nx = BIT_SPACE;
                    else                       err = 1'b1;
                  end
      BIT_SPACE:  if (fall) begin
                    if (in_win(width, 40, 70)) do_shift = 1'b1;
                    else if (in_win(width, 140, 200)) begin
                      do_shift = 1'b1;
                      bit_val  = 1'b1;
                    end else err = 1'b1;
                    if (do_shift) state_nx = (bit_cnt == 5'd31) ? DATA_STOP : BIT_MARK;
                  end
      DATA_STOP:  if (rise) begin
                    if (in_win(width, 40, 70) && frame_ok) acc_new = 1'b1;
                    else                                   err = 1'b1;
                    state_nx = IDLE;
                  end
      RPT_STOP:   if (rise) begin
                    if (in_win(width, 40, 70) && last_ok) acc_rpt = 1'b1;
                    else                                  err = 1'b1;
                    state_nx = IDLE;
                  end
      default:    state_nx = IDLE;
    endcase
    // A line stuck in one phase mid-frame is abandoned
    if (state != IDLE && !edge_det && width >= W_TIMEOUT) err = 1'b1;
    if (err) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bit_cnt <= '0;
    else if (clr_bits) bit_cnt <= '0;
    else if (do_shift) bit_cnt <= bit_cnt + 5'd1;
  end

  // NEC sends LSB first, so bits enter at the top and shift down
  always_ff @(posedge clk) begin
    if (do_shift) frame <= {bit_val, frame[31:1]};
  end

  assign code = acc_rpt ? cmd_q : frame[23:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      cmd_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      last_ok  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      valid_q <= acc_new | acc_rpt;
      err_q   <= err;
      if (acc_new || acc_rpt) begin
        cmd_q    <= code;
        last_ok  <= 1'b1;
        idle_cnt <= '0;
        case (code)
          8'h01:   r_q <= sat_inc(r_q);
          8'h02:   r_q <= sat_dec(r_q);
          8'h03:   g_q <= sat_inc(g_q);
          8'h04:   g_q <= sat_dec(g_q);
          8'h05:   b_q <= sat_inc(b_q);
          8'h06:   b_q <= sat_dec(b_q);
          8'h07:   begin r_q <= 3'd0; g_q <= 3'd0; b_q <= 3'd0; end
          8'h08:   begin r_q <= 3'd7; g_q <= 3'd7; b_q <= 3'd7; end
          default: ;
        endcase
      end else if (err) begin
        last_ok <= 1'b0;
      end else if (state == IDLE && last_ok && tick) begin
        if (idle_cnt == 14'(REPEAT_WIN - 1)) begin
          last_ok  <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 14'd1;
        end
      end
    end
  end

  assign bus.r         = r_q;
  assign bus.g         = g_q;
  assign bus.b         = b_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = valid_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_ir_color_ctrl.sv
`timescale 1ns/1ps
// Directed NEC frame bench for ir_color_ctrl; one tick per clock keeps frames short,
// and the repeat window is shortened to match.
module tb_ir_color_ctrl;
  localparam int TD   = 1;
  localparam int RW   = 3000;
  localparam int T_LM = 820;
  localparam int T_LS = 420;
  localparam int T_RS = 210;
  localparam int T_BM = 45;
  localparam int T_B0 = 45;
  localparam int T_B1 = 145;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ir_color_if bus ();

  ir_color_ctrl #(.TICK_DIV(TD), .ADDR(8'h00), .REPEAT_WIN(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #50 clk = ~clk;

  int     checks = 0;
  int     passes = 0;
  int     nv = 0;
  int     ne = 0;
  longint cyc = 0;
  longint acc_cyc = 0;
  int     mr = 0, mg = 0, mb = 0, mcmd = 0;
  bit     m_ok = 1'b0;
  bit     pending = 1'b1;
  int     e0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic void apply(input int c);
    case (c)
      1: mr = (mr < 7) ? mr + 1 : 7;
      2: mr = (mr > 0) ? mr - 1 : 0;
      3: mg = (mg < 7) ? mg + 1 : 7;
      4: mg = (mg > 0) ? mg - 1 : 0;
      5: mb = (mb < 7) ? mb + 1 : 7;
      6: mb = (mb > 0) ? mb - 1 : 0;
      7: begin mr = 0; mg = 0; mb = 0; end
      8: begin mr = 7; mg = 7; mb = 7; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] mkf(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.cmd_valid === 1'b1) nv++;
      if (bus.frame_err === 1'b1) ne++;
      if (!pending) begin
        checks++;
        if (bus.r == 3'(mr) && bus.g == 3'(mg) && bus.b == 3'(mb) && bus.cmd == 8'(mcmd))
          passes++;
        else
          $display("FAIL track @cyc %0d: got r=%0d g=%0d b=%0d cmd=%02h, expected r=%0d g=%0d b=%0d cmd=%02h",
                   cyc, bus.r, bus.g, bus.b, bus.cmd, mr, mg, mb, mcmd);
      end
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    bus.ir_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_head(input logic [31:0] f, input int nbits);
    hold(1'b0, T_LM);
    hold(1'b1, T_LS);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, T_BM);
      hold(1'b1, f[i] ? T_B1 : T_B0);
    end
  endtask

  // Ends a frame with its final rising edge and settles the model
  task automatic finish(input bit ok, input int code);
    int v0, x0;
    v0 = nv;
    x0 = ne;
    pending   = 1'b1;
    bus.ir_in = 1'b1;
    repeat (8) @(negedge clk);
    if (ok) begin
      mcmd = code;
      apply(code);
      m_ok    = 1'b1;
      acc_cyc = cyc;
    end else begin
      m_ok = 1'b0;
    end
    pending = 1'b0;
    check("cmd_valid pulses", nv - v0, ok ? 1 : 0);
    check("frame_err pulses", ne - x0, ok ? 0 : 1);
  endtask

  task automatic send_frame(input logic [31:0] f);
    bit good;
    send_head(f, 32);
    hold(1'b0, T_BM);
    good = (f[7:0] == 8'h00) && (f[15:8] == 8'hFF) && (f[31:24] == ~f[23:16]);
    finish(good, int'(f[23:16]));
  endtask

  task automatic send_rpt();
    bit ok;
    hold(1'b0, T_LM);
    hold(1'b1, T_RS);
    hold(1'b0, T_BM);
    ok = m_ok && ((cyc - acc_cyc) < longint'(RW * TD));
    finish(ok, mcmd);
  endtask

  initial begin
    bus.ir_in = 1'b1;
    rst_n     = 1'b0;
    fork
      monitor();
    join_none
    repeat (4) @(negedge clk);
    check("reset r", int'(bus.r), 0);
    check("reset g", int'(bus.g), 0);
    check("reset b", int'(bus.b), 0);
    check("reset cmd", int'(bus.cmd), 0);
    check("reset cmd_valid", int'(bus.cmd_valid), 0);
    check("reset frame_err", int'(bus.frame_err), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    pending = 1'b0;

    send_frame(mkf(8'h00, 8'h01));
    check("first frame r", int'(bus.r), 1);
    check("first frame g", int'(bus.g), 0);
    check("first frame b", int'(bus.b), 0);
    check("first frame cmd", int'(bus.cmd), 8'h01);
    hold(1'b1, 100);

    for (int k = 0; k < 7; k++) begin
      send_frame(mkf(8'h00, 8'h01));
      hold(1'b1, 100);
    end
    check("r saturated", int'(bus.r), 7);
    hold(1'b1, 1000);
    send_rpt();
    check("r after repeat", int'(bus.r), 7);
    check("cmd_valid total", nv, 9);

    hold(1'b1, 100);
    send_frame({8'hFF, 8'h03, 8'hFF, 8'h00});
    check("g after bad checksum", int'(bus.g), 0);
    hold(1'b1, 100);
    send_rpt();
    check("frame_err total", ne, 2);

    hold(1'b1, 100);
    hold(1'b0, 600);
    finish(1'b0, 0);

    hold(1'b1, 100);
    send_head(mkf(8'h00, 8'h08), 10);
    hold(1'b0, 300);
    finish(1'b0, 0);

    hold(1'b1, 100);
    e0 = ne;
    hold(1'b0, 1200);
    hold(1'b1, 8);
    m_ok = 1'b0;
    check("timeout frame_err", ne - e0, 1);

    hold(1'b1, 100);
    send_frame(mkf(8'h00, 8'h08));
    check("all-max r", int'(bus.r), 7);
    check("all-max g", int'(bus.g), 7);
    check("all-max b", int'(bus.b), 7);

    hold(1'b1, 3500);
    send_rpt();
    check("g after expired repeat", int'(bus.g), 7);

    hold(1'b1, 100);
    send_head(mkf(8'h00, 8'h05), 20);
    hold(1'b0, 20);
    pending = 1'b1;
    rst_n   = 1'b0;
    mr = 0; mg = 0; mb = 0; mcmd = 0;
    m_ok = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-frame reset r", int'(bus.r), 0);
    check("mid-frame reset cmd", int'(bus.cmd), 0);
    bus.ir_in = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    pending = 1'b0;

    hold(1'b1, 100);
    send_frame(mkf(8'h00, 8'h06));
    check("post-reset cmd", int'(bus.cmd), 8'h06);
    check("b held at 0", int'(bus.b), 0);
    hold(1'b1, 20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
